// File: rtl/fifo_pkg.sv
// Shared helpers for param_circular_fifo: pointer sizing and parameter legality checks.
package fifo_pkg;

    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value >= 2) && ((value & (value - 1)) == 0);
    endfunction

    // Legal when DEPTH is a power of two, AF_THRESH in 1..DEPTH, AE_THRESH in 0..DEPTH-1.
    function automatic bit params_ok(input int depth, input int af_thresh, input int ae_thresh);
        return is_pow2(depth) &&
               (af_thresh >= 1) && (af_thresh <= depth) &&
               (ae_thresh >= 0) && (ae_thresh <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-bit FIFO pointer: PTRWID-bit counter split into entry index and wrap bit.
module fifo_ptr #(
    parameter int PTRWID = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_inc,
    output logic [PTRWID-1:0] o_ptr,
    output logic [PTRWID-2:0] o_idx,
    output logic              o_wrap
);

    logic [PTRWID-1:0] r_ptr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= r_ptr + PTRWID'(1);
        end
    end

    assign o_ptr  = r_ptr;
    assign o_idx  = r_ptr[PTRWID-2:0];
    assign o_wrap = r_ptr[PTRWID-1];

endmodule

// File: rtl/param_circular_fifo.sv
// Single-clock circular FIFO with count, threshold flags, sticky error flags and
// selectable first-word-fall-through or registered read output.
module param_circular_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int PTRWID    = ptr_width(DEPTH),
    parameter int AF_THRESH = DEPTH - 1,
    parameter int AE_THRESH = 1,
    parameter int FWFT      = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              clr_err,
    output logic [WIDTH-1:0]  data_out,
    output logic              out_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [PTRWID-1:0] count,
    output logic              overflow,
    output logic              underflow
);

    if (!params_ok(DEPTH, AF_THRESH, AE_THRESH) || (PTRWID != ptr_width(DEPTH))) begin : g_param_check
        $error("param_circular_fifo: illegal DEPTH/AF_THRESH/AE_THRESH/PTRWID combination");
    end

    logic [PTRWID-1:0] w_wr_ptr;
    logic [PTRWID-1:0] w_rd_ptr;
    logic [PTRWID-2:0] w_wr_idx;
    logic [PTRWID-2:0] w_rd_idx;
    logic              w_wr_wrap;
    logic              w_rd_wrap;
    logic              w_empty;
    logic              w_full;
    logic              w_pop_acc;
    logic              w_push_acc;
    logic [PTRWID-1:0] w_count;

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic              r_overflow;
    logic              r_underflow;

    fifo_ptr #(.PTRWID(PTRWID)) u_wr_ptr (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_inc   (w_push_acc),
        .o_ptr   (w_wr_ptr),
        .o_idx   (w_wr_idx),
        .o_wrap  (w_wr_wrap)
    );

    fifo_ptr #(.PTRWID(PTRWID)) u_rd_ptr (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_inc   (w_pop_acc),
        .o_ptr   (w_rd_ptr),
        .o_idx   (w_rd_idx),
        .o_wrap  (w_rd_wrap)
    );

    assign w_empty    = (w_wr_ptr == w_rd_ptr);
    assign w_full     = (w_wr_idx == w_rd_idx) && (w_wr_wrap != w_rd_wrap);
    assign w_count    = w_wr_ptr - w_rd_ptr;
    assign w_pop_acc  = pop & ~w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
    assign w_push_acc = push & (~w_full | w_pop_acc);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push_acc) begin
            r_mem[w_wr_idx] <= data_in;
        end
    end

    // Clear first so that a same-cycle error set takes priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (clr_err) begin
                r_overflow  <= 1'b0;
                r_underflow <= 1'b0;
            end
            if (push && w_full && !w_pop_acc) begin
                r_overflow <= 1'b1;
            end
            if (pop && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign empty        = w_empty;
    assign full         = w_full;
    assign count        = w_count;
    assign almost_full  = (w_count >= PTRWID'(AF_THRESH));
    assign almost_empty = (w_count <= PTRWID'(AE_THRESH));
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    if (FWFT != 0) begin : g_fwft
        assign data_out  = r_mem[w_rd_idx];
        assign out_valid = ~w_empty;
    end else begin : g_registered
        logic [WIDTH-1:0] r_data_out;
        logic             r_out_valid;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_data_out  <= '0;
                r_out_valid <= 1'b0;
            end else begin
                r_out_valid <= w_pop_acc;
                if (w_pop_acc) begin
                    r_data_out <= r_mem[w_rd_idx];
                end
            end
        end

        assign data_out  = r_data_out;
        assign out_valid = r_out_valid;
    end

endmodule

// File: tb/tb_param_circular_fifo.sv
// Randomised and directed bench for param_circular_fifo, both output modes side by side.
module tb_param_circular_fifo;

    localparam int W    = 8;
    localparam int D    = 8;
    localparam int PW   = 4;
    localparam int AF   = D - 1;
    localparam int AE   = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic [W-1:0]  data_in = '0;
    logic          clr_err = 1'b0;

    logic [W-1:0]  a_dout, b_dout;
    logic          a_ov, b_ov, a_full, b_full, a_empty, b_empty;
    logic          a_af, b_af, a_ae, b_ae, a_ovf, b_ovf, a_unf, b_unf;
    logic [PW-1:0] a_cnt, b_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: a plain queue plus sticky flags and the registered-read output.
    logic [W-1:0] q[$];
    bit           m_ovf = 0, m_unf = 0;
    logic [W-1:0] m_dout0 = '0;
    bit           m_ov0 = 0;

    always #5 clk = ~clk;

    param_circular_fifo #(.WIDTH(W), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) dut_a (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .data_in(data_in), .clr_err(clr_err),
        .data_out(a_dout), .out_valid(a_ov), .full(a_full), .empty(a_empty),
        .almost_full(a_af), .almost_empty(a_ae), .count(a_cnt),
        .overflow(a_ovf), .underflow(a_unf)
    );

    param_circular_fifo #(.WIDTH(W), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) dut_b (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .data_in(data_in), .clr_err(clr_err),
        .data_out(b_dout), .out_valid(b_ov), .full(b_full), .empty(b_empty),
        .almost_full(b_af), .almost_empty(b_ae), .count(b_cnt),
        .overflow(b_ovf), .underflow(b_unf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                q.delete();
                m_ovf   = 0;
                m_unf   = 0;
                m_dout0 = '0;
                m_ov0   = 0;
            end else begin
                bit pop_acc, push_acc;
                pop_acc  = pop && (q.size() > 0);
                push_acc = push && ((q.size() < D) || pop_acc);
                if (clr_err) begin
                    m_ovf = 0;
                    m_unf = 0;
                end
                if (push && !push_acc) m_ovf = 1;
                if (pop && !pop_acc)   m_unf = 1;
                m_ov0 = pop_acc;
                if (pop_acc) m_dout0 = q.pop_front();
                if (push_acc) q.push_back(data_in);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("a_count", 32'(a_cnt), 32'(q.size()));
            chk("b_count", 32'(b_cnt), 32'(q.size()));
            chk("a_empty", 32'(a_empty), 32'(q.size() == 0));
            chk("b_empty", 32'(b_empty), 32'(q.size() == 0));
            chk("a_full", 32'(a_full), 32'(q.size() == D));
            chk("b_full", 32'(b_full), 32'(q.size() == D));
            chk("a_almost_full", 32'(a_af), 32'(q.size() >= AF));
            chk("b_almost_full", 32'(b_af), 32'(q.size() >= AF));
            chk("a_almost_empty", 32'(a_ae), 32'(q.size() <= AE));
            chk("b_almost_empty", 32'(b_ae), 32'(q.size() <= AE));
            chk("a_overflow", 32'(a_ovf), 32'(m_ovf));
            chk("b_overflow", 32'(b_ovf), 32'(m_ovf));
            chk("a_underflow", 32'(a_unf), 32'(m_unf));
            chk("b_underflow", 32'(b_unf), 32'(m_unf));
            chk("a_out_valid", 32'(a_ov), 32'(q.size() > 0));
            if (q.size() > 0) chk("a_data_out", 32'(a_dout), 32'(q[0]));
            chk("b_out_valid", 32'(b_ov), 32'(m_ov0));
            chk("b_data_out", 32'(b_dout), 32'(m_dout0));
        end
    end

    task automatic step(input bit p, input bit po, input logic [W-1:0] d, input bit c);
        @(negedge clk);
        push = p; pop = po; data_in = d; clr_err = c;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_values();
        chk("rst_a_count", 32'(a_cnt), 0);
        chk("rst_b_count", 32'(b_cnt), 0);
        chk("rst_a_empty", 32'(a_empty), 1);
        chk("rst_b_empty", 32'(b_empty), 1);
        chk("rst_a_full", 32'(a_full), 0);
        chk("rst_a_ae", 32'(a_ae), 1);
        chk("rst_a_af", 32'(a_af), 0);
        chk("rst_a_ovf", 32'(a_ovf), 0);
        chk("rst_b_unf", 32'(b_unf), 0);
        chk("rst_a_ov", 32'(a_ov), 0);
        chk("rst_b_ov", 32'(b_ov), 0);
        chk("rst_a_dout", 32'(a_dout), 0);
        chk("rst_b_dout", 32'(b_dout), 0);
    endtask

    logic [W-1:0] drain_exp [8];

    initial begin
        drain_exp[0] = 8'h02; drain_exp[1] = 8'h03; drain_exp[2] = 8'h04; drain_exp[3] = 8'h05;
        drain_exp[4] = 8'h06; drain_exp[5] = 8'h07; drain_exp[6] = 8'h08; drain_exp[7] = 8'hAA;

        #1 rst = 1'b0;
        #1 chk_reset_values();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 1; i <= 8; i++) begin
            step(1, 0, W'(i), 0);
            if (i == 7) begin
                chk("af_after_7", 32'(a_af), 1);
                chk("full_after_7", 32'(a_full), 0);
                chk("count_after_7", 32'(a_cnt), 7);
            end
        end
        chk("full_after_8", 32'(a_full), 1);
        chk("count_after_8", 32'(a_cnt), 8);
        chk("fwft_head", 32'(a_dout), 32'h01);

        step(1, 1, 8'hAA, 0);
        chk("pp_full_count", 32'(a_cnt), 8);
        chk("pp_full_ovf", 32'(a_ovf), 0);
        chk("pp_fwft_head", 32'(a_dout), 32'h02);
        chk("pp_reg_dout", 32'(b_dout), 32'h01);
        chk("pp_reg_valid", 32'(b_ov), 1);

        step(1, 0, 8'hBB, 0);
        chk("ovf_set", 32'(a_ovf), 1);
        chk("ovf_count", 32'(a_cnt), 8);
        chk("ovf_head", 32'(a_dout), 32'h02);
        step(0, 0, 8'h00, 1);
        chk("ovf_cleared", 32'(a_ovf), 0);

        for (int i = 0; i < 8; i++) begin
            chk("drain_fwft", 32'(a_dout), 32'(drain_exp[i]));
            step(0, 1, 8'h00, 0);
            chk("drain_reg", 32'(b_dout), 32'(drain_exp[i]));
        end
        chk("drained_empty", 32'(a_empty), 1);

        step(1, 1, 8'h55, 0);
        chk("pe_count", 32'(a_cnt), 1);
        chk("pe_unf", 32'(a_unf), 1);
        chk("pe_reg_valid", 32'(b_ov), 0);
        chk("pe_fwft_dout", 32'(a_dout), 32'h55);
        step(0, 1, 8'h00, 1);
        chk("pe_pop_reg", 32'(b_dout), 32'h55);
        chk("pe_unf_clr", 32'(a_unf), 0);

        step(1, 0, 8'h11, 0);
        step(1, 0, 8'h22, 0);
        step(0, 1, 8'h00, 0);
        chk("reg_pulse_valid", 32'(b_ov), 1);
        chk("reg_pulse_data", 32'(b_dout), 32'h11);
        step(0, 0, 8'h00, 0);
        chk("reg_hold_valid", 32'(b_ov), 0);
        chk("reg_hold_data", 32'(b_dout), 32'h11);

        // Randomised phase with phase-varying bias to reach both full and empty repeatedly.
        for (int n = 0; n < 800; n++) begin
            int bias;
            bias = ((n / 60) % 3);
            @(negedge clk);
            case (bias)
                0: begin push = ($urandom_range(0, 9) < 8); pop = ($urandom_range(0, 9) < 3); end
                1: begin push = ($urandom_range(0, 9) < 3); pop = ($urandom_range(0, 9) < 8); end
                default: begin push = $urandom_range(0, 1) == 1; pop = $urandom_range(0, 1) == 1; end
            endcase
            data_in = W'($urandom);
            clr_err = ($urandom_range(0, 15) == 0);
            if (n == 400) begin
                #2 rst = 1'b0;
                #1 chk_reset_values();
                #1 rst = 1'b1;
            end
        end

        step(0, 0, 8'h00, 0);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: got no completion expected finish before 200000");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
